// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester write-back arbiter with per-requester FIFOs feeding a register file write port
// Optional feature macro: WB_ARB_RR_EN (round-robin arbitration; undefined = fixed priority, A wins)
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  output logic            we,
  output logic [AW-1:0]   wr,
  output logic [XLEN-1:0] wd,
  input  logic [AW-1:0]   qry_rd,
  output logic            qry_pend
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = AW + XLEN;
  localparam logic [PW:0] PTR_ONE  = (PW+1)'(1);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  // Index 0 is requester A, index 1 is requester B; entries are {rd, data}
  logic [EW-1:0]   mem_q [2][DEPTH];
  logic [PW:0]     wp_q  [2];
  logic [PW:0]     rp_q  [2];
  logic [PW:0]     cnt   [2];
  logic [EW-1:0]   in_ent[2];
  logic [EW-1:0]   head  [2];
  logic [1:0]      in_valid;
  logic [1:0]      full;
  logic [1:0]      empty;
  logic [1:0]      rdy;
  logic [1:0]      push;
  logic [1:0]      gnt;
  logic [EW-1:0]   sel;
  logic            we_q, we_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            hit;
  logic [PW-1:0]   off;
`ifdef WB_ARB_RR_EN
  logic            prio_q, prio_d;
`endif

  assign in_valid  = {b_valid, a_valid};
  assign in_ent[0] = {a_rd, a_data};
  assign in_ent[1] = {b_rd, b_data};

  // FIFO occupancy from wrap-bit pointers; ready never depends on valid or on a same-cycle pop
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      cnt[r]   = wp_q[r] - rp_q[r];
      empty[r] = (cnt[r] == '0);
      full[r]  = (cnt[r] == CNT_FULL);
      rdy[r]   = !rst && !full[r];
      push[r]  = in_valid[r] && rdy[r];
      head[r]  = mem_q[r][rp_q[r][PW-1:0]];
    end
  end

  // Pick one head per cycle and form the next write-port value; rd=0 heads are dropped silently
  always_comb begin
`ifdef WB_ARB_RR_EN
    gnt[1] = !empty[1] && (empty[0] || prio_q);
    prio_d = (!empty[0] && !empty[1]) ? !prio_q : prio_q;
`else
    gnt[1] = !empty[1] && empty[0];
`endif
    gnt[0] = !empty[0] && !gnt[1];
    sel    = gnt[1] ? head[1] : head[0];
    we_d   = 1'b0;
    wr_d   = wr_q;
    wd_d   = wd_q;
    if ((|gnt) && (sel[EW-1:XLEN] != '0)) begin
      we_d = 1'b1;
      wr_d = sel[EW-1:XLEN];
      wd_d = sel[XLEN-1:0];
    end
  end

  // Hazard query: any occupied FIFO slot or the in-flight write targeting qry_rd
  always_comb begin
    hit = we_q && (wr_q == qry_rd);
    off = '0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        off = PW'(i) - rp_q[r][PW-1:0];
        if (({1'b0, off} < cnt[r]) && (mem_q[r][i][EW-1:XLEN] == qry_rd)) hit = 1'b1;
      end
    end
    qry_pend = hit && (qry_rd != '0);
  end

  // Pointers, write-port register and arbitration pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 2; r++) begin
        wp_q[r] <= '0;
        rp_q[r] <= '0;
      end
      we_q <= 1'b0;
      wr_q <= '0;
      wd_q <= '0;
`ifdef WB_ARB_RR_EN
      prio_q <= 1'b0;
`endif
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (push[r]) wp_q[r] <= wp_q[r] + PTR_ONE;
        if (gnt[r])  rp_q[r] <= rp_q[r] + PTR_ONE;
      end
      we_q <= we_d;
      wr_q <= wr_d;
      wd_q <= wd_d;
`ifdef WB_ARB_RR_EN
      prio_q <= prio_d;
`endif
    end
  end

  // Entry storage, written only on accepted pushes (push is already blocked during reset)
  always_ff @(posedge clk) begin
    for (int r = 0; r < 2; r++) begin
      if (push[r]) mem_q[r][wp_q[r][PW-1:0]] <= in_ent[r];
    end
  end

  assign a_ready = rdy[0];
  assign b_ready = rdy[1];
  assign we      = we_q;
  assign wr      = wr_q;
  assign wd      = wd_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter against a queue-based reference model
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            a_valid, b_valid;
  logic [AW-1:0]   a_rd, b_rd, qry_rd;
  logic [XLEN-1:0] a_data, b_data;
  logic            a_ready, b_ready, we, qry_pend;
  logic [AW-1:0]   wr;
  logic [XLEN-1:0] wd;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.XLEN(XLEN), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .we(we), .wr(wr), .wd(wd),
    .qry_rd(qry_rd), .qry_pend(qry_pend)
  );

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t            qa[$];
  ent_t            qb[$];
  logic            m_we;
  logic [AW-1:0]   m_wr;
  logic [XLEN-1:0] m_wd;
`ifdef WB_ARB_RR_EN
  logic            m_prio_b;
`endif
  int n_vec = 0;
  int n_err = 0;

  // One clock cycle: drive inputs at negedge, compare against the model, then advance the model at posedge
  task automatic cycle(input logic r, input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                       input logic bv, input logic [AW-1:0] brd, input logic [XLEN-1:0] bd,
                       input logic [AW-1:0] qrd);
    logic e_ar, e_br, e_pend, gv;
    ent_t g;
    @(negedge clk);
    rst = r; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd; qry_rd = qrd;
    #1;
    e_ar   = !r && (qa.size() < DEPTH);
    e_br   = !r && (qb.size() < DEPTH);
    e_pend = 1'b0;
    if (qrd != '0) begin
      foreach (qa[i]) if (qa[i].rd == qrd) e_pend = 1'b1;
      foreach (qb[i]) if (qb[i].rd == qrd) e_pend = 1'b1;
      if (m_we && (m_wr == qrd)) e_pend = 1'b1;
    end
    n_vec++; if (a_ready !== e_ar) begin n_err++; $display("FAIL a_ready: got %b expected %b at %0t", a_ready, e_ar, $time); end
    n_vec++; if (b_ready !== e_br) begin n_err++; $display("FAIL b_ready: got %b expected %b at %0t", b_ready, e_br, $time); end
    n_vec++; if (qry_pend !== e_pend) begin n_err++; $display("FAIL qry_pend(rd=%0d): got %b expected %b at %0t", qrd, qry_pend, e_pend, $time); end
    n_vec++; if (we !== m_we) begin n_err++; $display("FAIL we: got %b expected %b at %0t", we, m_we, $time); end
    n_vec++; if (wr !== m_wr) begin n_err++; $display("FAIL wr: got %0d expected %0d at %0t", wr, m_wr, $time); end
    n_vec++; if (wd !== m_wd) begin n_err++; $display("FAIL wd: got %h expected %h at %0t", wd, m_wd, $time); end
    @(posedge clk);
    if (r) begin
      qa.delete(); qb.delete();
      m_we = 1'b0; m_wr = '0; m_wd = '0;
`ifdef WB_ARB_RR_EN
      m_prio_b = 1'b0;
`endif
    end else begin
      gv = 1'b0;
      g  = '0;
      if (qa.size() > 0 && qb.size() > 0) begin
`ifdef WB_ARB_RR_EN
        if (m_prio_b) g = qb.pop_front(); else g = qa.pop_front();
        m_prio_b = !m_prio_b;
`else
        g = qa.pop_front();
`endif
        gv = 1'b1;
      end else if (qa.size() > 0) begin
        g = qa.pop_front(); gv = 1'b1;
      end else if (qb.size() > 0) begin
        g = qb.pop_front(); gv = 1'b1;
      end
      if (gv && g.rd != '0) begin
        m_we = 1'b1; m_wr = g.rd; m_wd = g.data;
      end else begin
        m_we = 1'b0;
      end
      if (av && e_ar) qa.push_back({ard, ad});
      if (bv && e_br) qb.push_back({brd, bd});
    end
  endtask

  task automatic idle(input int n, input logic [AW-1:0] qrd);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, qrd);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 5'd5);
    cycle(1'b1, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'h2222_2222, 5'd6);
    #2;
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b%b expected 00", a_ready, b_ready); end
    n_vec++; if (we !== 1'b0 || wr !== '0 || wd !== '0) begin n_err++; $display("FAIL reset_out: got we=%b wr=%0d wd=%h expected 0/0/0", we, wr, wd); end
    idle(1, 5'd5);
    #2;
    n_vec++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b%b expected 11", a_ready, b_ready); end
  endtask

  task automatic test_single();
    cycle(1'b0, 1'b1, 5'd5, 32'h0123_4567, 1'b0, '0, '0, 5'd5);
    idle(1, 5'd5);
    #2;
    n_vec++; if (we !== 1'b1 || wr !== 5'd5 || wd !== 32'h0123_4567) begin n_err++; $display("FAIL single_write: got we=%b wr=%0d wd=%h expected 1/5/01234567", we, wr, wd); end
    idle(1, 5'd5);
    #2;
    n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL single_we_drop: got %b expected 0", we); end
  endtask

  task automatic test_rd_zero();
    cycle(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0, 5'd0);
    idle(2, 5'd0);
    #2;
    n_vec++; if (we !== 1'b0 || wr !== 5'd5 || wd !== 32'h0123_4567) begin n_err++; $display("FAIL rd_zero_hold: got we=%b wr=%0d wd=%h expected 0/5/01234567", we, wr, wd); end
  endtask

  task automatic test_both();
    logic [AW-1:0] exp_first;
    cycle(1'b0, 1'b1, 5'd7, 32'h8888_4444, 1'b1, 5'd4, 32'h0123_4588, 5'd4);
    idle(1, 5'd7);
    #2;
    n_vec++; if (wr !== 5'd7 || we !== 1'b1) begin n_err++; $display("FAIL both_first: got we=%b wr=%0d expected 1/7", we, wr); end
    idle(2, 5'd4);
    cycle(1'b0, 1'b1, 5'd7, 32'h8888_4444, 1'b1, 5'd4, 32'h0123_4588, 5'd7);
    idle(1, 5'd4);
`ifdef WB_ARB_RR_EN
    exp_first = 5'd4;
`else
    exp_first = 5'd7;
`endif
    #2;
    n_vec++; if (wr !== exp_first || we !== 1'b1) begin n_err++; $display("FAIL both_repeat_first: got we=%b wr=%0d expected 1/%0d", we, wr, exp_first); end
    idle(2, 5'd7);
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, AW'(k + 1), 32'hA000_0000 + k, k < DEPTH, AW'(12 + k), 32'hB000_0000 + k, 5'd12);
`ifndef WB_ARB_RR_EN
      if (k == DEPTH - 1) begin
        #2;
        n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL fill_b_ready: got %b expected 0", b_ready); end
      end
`endif
    end
    idle(6, 5'd13);
  endtask

  task automatic test_query();
    cycle(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_0099, 5'd9);
    #2;
    n_vec++; if (qry_pend !== 1'b1) begin n_err++; $display("FAIL query_after_push: got %b expected 1", qry_pend); end
    idle(3, 5'd9);
    idle(1, 5'd10);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++)
      cycle(1'b0, 1'b1, AW'(20 + k), $urandom, 1'b1, AW'(25 + k), $urandom, AW'(20 + k));
    cycle(1'b1, 1'b1, 5'd30, 32'h3030_3030, 1'b1, 5'd31, 32'h3131_3131, 5'd21);
    #2;
    n_vec++; if (we !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL mid_reset: got we=%b ready=%b%b expected 0/00", we, a_ready, b_ready); end
    for (int q = 0; q < 32; q++) idle(1, AW'(q));
  endtask

  task automatic test_random();
    logic r;
    for (int k = 0; k < 1500; k++) begin
      r = ($urandom_range(0, 63) == 0);
      cycle(r, 1'($urandom), ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom), $urandom,
            1'($urandom), ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom), $urandom, AW'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_rd = '0; b_rd = '0;
    a_data = '0; b_data = '0; qry_rd = '0;
    m_we = 1'b0; m_wr = '0; m_wd = '0;
`ifdef WB_ARB_RR_EN
    m_prio_b = 1'b0;
`endif
    test_reset();
    test_single();
    test_rd_zero();
    test_both();
    test_fill();
    test_query();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
